// File: rtl/top_divisor.sv
// rtl/top_divisor.sv - sequential restoring divider, one quotient bit per clock
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous active-high reset
//   init      in   start request, sampled only while idle
//   A         in   WA-bit dividend, captured on the start edge
//   B         in   WB-bit divisor, captured on the start edge
//   quotient  out  WA-bit registered quotient
//   remainder out  WB-bit registered remainder
//   done      out  one-cycle completion pulse
//   div_zero  out  set alongside the result when the divisor was zero

module top_divisor #(
  parameter int WA = 11,
  parameter int WB = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic [WA-1:0] quotient,
  output logic [WB-1:0] remainder,
  output logic          done,
  output logic          div_zero
);

  localparam int CW = $clog2(WA);
  localparam logic [CW-1:0] LAST = CW'(WA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [WA-1:0] dq;       // dividend shifting out of the MSB, quotient bits in at the LSB
  logic [WB-1:0] dv;       // captured divisor
  logic [WB-1:0] r;        // partial remainder; always < dv, so its extra MSB is never needed
  logic [CW-1:0] count;

  logic [WB:0]   t;
  logic          ge;
  logic [WB-1:0] r_nxt;
  logic [WA-1:0] dq_nxt;
  logic          last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t         = {r, dq[WA-1]};
    ge        = (t >= {1'b0, dv});
    // When t >= dv the true difference is below dv, so WB-bit modular
    // subtraction yields it exactly.
    r_nxt     = ge ? (t[WB-1:0] - dv) : t[WB-1:0];
    dq_nxt    = {dq[WA-2:0], ge};
    last      = (count == LAST);

    case (state)
      IDLE: begin
        if (init) begin
          state_nxt = (B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq        <= '0;
      dv        <= '0;
      r         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done is a flop that is high exactly while the FSM sits in DONE
      done <= (state_nxt == DONE);

      case (state)
        IDLE: begin
          if (init) begin
            dq    <= A;
            dv    <= B;
            r     <= '0;
            count <= '0;
            if (B == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          dq    <= dq_nxt;
          r     <= r_nxt;
          count <= count + CW'(1);
          if (last) begin
            quotient  <= dq_nxt;
            remainder <= r_nxt;
            div_zero  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_divisor.sv
// tb/tb_top_divisor.sv - self-checking bench for top_divisor

module tb_top_divisor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic [10:0] A = '0;
  logic [4:0]  B = '0;
  logic [10:0] quotient;
  logic [4:0]  remainder;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  top_divisor #(.WA(11), .WB(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .A         (A),
    .B         (B),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, with the all-ones/zero/flag answer for B == 0.
  function automatic void model(input int a, input int b, output int q, output int rm, output int dz);
    if (b == 0) begin
      q = 2047; rm = 0; dz = 1;
    end else begin
      q = a / b; rm = a % b; dz = 0;
    end
  endfunction

  // Presents operands for one start edge; returns just after that edge (edge 0).
  task automatic start_div(input logic [10:0] a, input logic [4:0] b);
    @(negedge clk);
    A = a; B = b; init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  // Returns the edge index (relative to the start edge) at which done is seen high.
  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (quotient !== 11'd0 || remainder !== 5'd0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got q=%0d r=%0d done=%0d dz=%0d, expected all 0", quotient, remainder, done, div_zero);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_done: got done=%0d, expected 0", done);
    end
  endtask

  task automatic test_exact;
    int lat;
    start_div(11'd1470, 5'd30);
    wait_done(lat);
    checks++;
    if (lat != 11 || quotient !== 11'd49 || remainder !== 5'd0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL exact_1470_30: got lat=%0d q=%0d r=%0d dz=%0d, expected lat=11 q=49 r=0 dz=0", lat, quotient, remainder, div_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got done=%0d on edge 12, expected 0", done);
    end
    // Result must hold while the next division is in progress.
    start_div(11'd2000, 5'd3);
    repeat (5) @(negedge clk);
    checks++;
    if (quotient !== 11'd49 || remainder !== 5'd0) begin
      failures++;
      $display("FAIL result_hold: got q=%0d r=%0d, expected q=49 r=0", quotient, remainder);
    end
    wait_done(lat);
  endtask

  task automatic test_operand_table;
    int tab_a[3] = '{2047, 5, 100};
    int tab_b[3] = '{31, 7, 1};
    int lat, q, rm, dz;
    for (int i = 0; i < 3; i++) begin
      model(tab_a[i], tab_b[i], q, rm, dz);
      start_div(11'(tab_a[i]), 5'(tab_b[i]));
      wait_done(lat);
      checks++;
      if (lat != 11 || int'(quotient) != q || int'(remainder) != rm || int'(div_zero) != dz) begin
        failures++;
        $display("FAIL table_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%0d, expected lat=11 q=%0d r=%0d dz=%0d",
                 tab_a[i], tab_b[i], lat, quotient, remainder, div_zero, q, rm, dz);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    start_div(11'd300, 5'd0);
    wait_done(lat);
    checks++;
    if (lat != 0 || quotient !== 11'd2047 || remainder !== 5'd0 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_zero: got lat=%0d q=%0d r=%0d dz=%0d, expected lat=0 q=2047 r=0 dz=1", lat, quotient, remainder, div_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_pulse: got done=%0d on edge 1, expected 0", done);
    end
    start_div(11'd9, 5'd3);
    wait_done(lat);
    checks++;
    if (lat != 11 || quotient !== 11'd3 || remainder !== 5'd0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL after_div_zero: got lat=%0d q=%0d r=%0d dz=%0d, expected lat=11 q=3 r=0 dz=0", lat, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_busy;
    int pulses = 0;
    int dk = -1;
    logic [10:0] q_seen = '0;
    logic [4:0]  r_seen = '0;
    start_div(11'd1470, 5'd30);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++; dk = k; q_seen = quotient; r_seen = remainder;
      end
      if (k == 4) begin
        init = 1'b1; A = 11'd10; B = 5'd2;
      end else begin
        init = 1'b0;
      end
    end
    checks++;
    if (pulses != 1 || dk != 11 || q_seen !== 11'd49 || r_seen !== 5'd0) begin
      failures++;
      $display("FAIL busy_ignore: got pulses=%0d edge=%0d q=%0d r=%0d, expected pulses=1 edge=11 q=49 r=0", pulses, dk, q_seen, r_seen);
    end
  endtask

  task automatic test_held_init;
    int edges[$];
    int exp_edges[3] = '{11, 24, 37};
    bit ok;
    @(negedge clk);
    A = 11'd12; B = 5'd5; init = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        edges.push_back(k);
        checks++;
        if (quotient !== 11'd2 || remainder !== 5'd2) begin
          failures++;
          $display("FAIL held_result: got q=%0d r=%0d at edge %0d, expected q=2 r=2", quotient, remainder, k);
        end
      end
    end
    init = 1'b0;
    // Restart lands on the first IDLE edge after DONE: 13 edges per run.
    ok = (edges.size() == 3);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        if (edges[i] != exp_edges[i]) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL held_timing: got %0d pulses at %p, expected pulses at edges 11 24 37", edges.size(), edges);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int lat;
    start_div(11'd1470, 5'd30);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (quotient !== 11'd0 || remainder !== 5'd0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got q=%0d r=%0d done=%0d dz=%0d, expected all 0", quotient, remainder, done, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses, expected 0", pulses);
    end
    start_div(11'd2047, 5'd31);
    wait_done(lat);
    checks++;
    if (lat != 11 || quotient !== 11'd66 || remainder !== 5'd1 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover: got lat=%0d q=%0d r=%0d dz=%0d, expected lat=11 q=66 r=1 dz=0", lat, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_random;
    int a, b, q, rm, dz, lat;
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 2047));
      b = int'($urandom_range(1, 31));
      model(a, b, q, rm, dz);
      start_div(11'(a), 5'(b));
      // Operands are free to change once captured.
      A = 11'($urandom); B = 5'($urandom);
      wait_done(lat);
      checks++;
      if (lat != 11 || int'(quotient) != q || int'(remainder) != rm || div_zero !== 1'b0 ||
          int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
        failures++;
        $display("FAIL random_%0d: A=%0d B=%0d got lat=%0d q=%0d r=%0d dz=%0d, expected lat=11 q=%0d r=%0d dz=0",
                 i, a, b, lat, quotient, remainder, div_zero, q, rm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_operand_table();
    test_div_zero();
    test_busy();
    test_held_init();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
